// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: state encoding and CRC-16-CCITT helpers shared by the configuration-chain loader.
package ccff_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready bitstream word port feeding the chain loader.
interface ccff_chain_loader_if #(parameter int DATA_W = 8) ();
    logic [DATA_W-1:0] s_data;
    logic s_valid;
    logic s_ready;
    modport master (output s_data, output s_valid, input s_ready);
    modport slave (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: one-word buffer that hands out bits LSB-first and refills without a bubble.
module ccff_word_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              allow,
    input  logic              more,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              ready,
    output logic              shift,
    output logic              head
);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    logic [DATA_W-1:0] word;
    logic [IW-1:0] idx;
    logic full, last;
    assign last = idx == IW'(DATA_W - 1);
    assign shift = full && allow;
    // A refill is only worth taking if the chain still needs bits after the one leaving now.
    assign ready = allow && (!full || (last && more));
    assign head = word[idx];
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            word <= '0;
            idx <= '0;
            full <= 1'b0;
        end else if (!allow) begin
            full <= 1'b0;
        end else if (s_valid && ready) begin
            word <= s_data;
            idx <= '0;
            full <= 1'b1;
        end else if (shift) begin
            full <= !last;
            idx <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serially loads the fabric configuration chain from a word-wide bitstream.
// Define CCFF_LOADER_CRC_EN to add a CRC-16-CCITT trailer check (CHECK/ERR states).
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 320,
    parameter int DATA_W = 8,
    parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             start,
    ccff_chain_loader_if.slave s,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             cfg_done,
    output logic             err,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
    state_t state, state_nx, load_end;
    logic allow, more, shift, ser_ready, head_bit, restart, fin, crc_ok, unused;
    assign unused = ccff_tail;
    assign allow = state == LOAD && bit_cnt <= LAST;
    assign more = bit_cnt < LAST;
    ccff_word_serializer #(.DATA_W(DATA_W)) u_ser (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .allow      (allow),
        .more       (more),
        .s_data     (s.s_data),
        .s_valid    (s.s_valid),
        .ready      (ser_ready),
        .shift      (shift),
        .head       (head_bit)
    );
    assign ccff_shift_en = shift;
    assign ccff_head = shift & head_bit;
    assign busy = state == LOAD || state == CHECK;
    assign cfg_done = state == DONE;
`ifdef CCFF_LOADER_CRC_EN
    localparam int TW = (16 + DATA_W - 1) / DATA_W;
    localparam int KW = TW > 1 ? $clog2(TW) : 1;
    localparam int RW = TW * DATA_W;
    logic [15:0] crc;
    logic [RW-1:0] rx, rx_nx;
    logic [KW-1:0] k;
    logic take;
    assign load_end = CHECK;
    assign take = state == CHECK && s.s_valid;
    assign fin = take && k == KW'(TW - 1);
    // Trailer words arrive LSB-first, so each new word enters at the top and slides down.
    assign rx_nx = (rx >> DATA_W) | (RW'(s.s_data) << ((TW - 1) * DATA_W));
    assign crc_ok = rx_nx[15:0] == crc;
    assign err = state == ERR;
    assign s.s_ready = ser_ready || state == CHECK;
    always_ff @(posedge prog_clk) begin
        if (!prog_reset || restart) begin
            crc <= CRC16_INIT;
            rx <= '0;
            k <= '0;
        end else begin
            if (shift)
                crc <= crc16_step(crc, head_bit);
            if (take) begin
                rx <= rx_nx;
                k <= k + 1'b1;
            end
        end
    end
`else
    assign load_end = DONE;
    assign fin = 1'b0;
    assign crc_ok = 1'b0;
    assign err = 1'b0;
    assign s.s_ready = ser_ready;
`endif
    always_comb begin
        state_nx = state;
        if (start && (state == IDLE || state == DONE || state == ERR))
            state_nx = LOAD;
        else if (state == LOAD && shift && bit_cnt == LAST)
            state_nx = load_end;
        else if (fin)
            state_nx = crc_ok ? DONE : ERR;
    end
    assign restart = state_nx == LOAD && state != LOAD;
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state <= IDLE;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            if (restart)
                bit_cnt <= '0;
            else if (shift)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed and random loads into a 20-bit chain model with hand-computed images.
`timescale 1ns/1ps
module tb_ccff_chain_loader;
    localparam int LEN = 20;
    localparam int DW = 8;
    localparam int CW = $clog2(LEN + 1);
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic tail, head, shift_en, busy, cfg_done, err;
    logic [CW-1:0] bit_cnt;
    logic [LEN-1:0] chain = '0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nsh = 0;
    int last_sh = 0;
    int t_first = 0;
    ccff_chain_loader_if #(.DATA_W(DW)) bs ();
    ccff_chain_loader #(.CHAIN_LEN(LEN), .DATA_W(DW)) dut (
        .prog_clk      (clk),
        .prog_reset    (rst),
        .start         (start),
        .s             (bs),
        .ccff_head     (head),
        .ccff_shift_en (shift_en),
        .ccff_tail     (tail),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .err           (err),
        .bit_cnt       (bit_cnt)
    );
    always #5 clk = ~clk;
    assign tail = chain[0];
    always @(posedge clk) if (shift_en) chain <= {head, chain[LEN-1:1]};
    always @(negedge clk) begin
        cyc++;
        if (shift_en) begin
            nsh++;
            last_sh = cyc;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] crc_of(input logic [LEN-1:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < LEN; i++)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic push(input logic [7:0] w);
        int n;
        n = 0;
        bs.s_data = w;
        bs.s_valid = 1'b1;
        while (!bs.s_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_ready", {31'd0, bs.s_ready}, 1);
        tick();
    endtask
    task automatic wait_end();
        int n;
        n = 0;
        while (!(cfg_done || err) && n < 200) begin
            tick();
            n++;
        end
        check("end_seen", {31'd0, cfg_done | err}, 1);
    endtask
    task automatic push_trailer(input logic [15:0] c);
`ifdef CCFF_LOADER_CRC_EN
        push(c[7:0]);
        push(c[15:8]);
`else
        if (c == 16'h0) bs.s_valid = 1'b0;
`endif
    endtask
    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int gap, input bit flip);
        logic [15:0] c;
        c = crc_of({w2[3:0], w1, w0}) ^ {15'd0, flip};
        pulse_start();
        push(w0);
        t_first = cyc;
        if (gap > 0) begin
            bs.s_valid = 1'b0;
            repeat (8) tick();
            for (int i = 0; i < gap; i++) begin
                check("gap_shift", {31'd0, shift_en}, 0);
                check("gap_cnt", 32'(bit_cnt), 8);
                tick();
            end
        end
        push(w1);
        push(w2);
        check("tail_ready", {31'd0, bs.s_ready}, 0);
        push_trailer(c);
        bs.s_valid = 1'b0;
        wait_end();
    endtask
    initial begin
        int n, s0;
        logic [7:0] r0, r1, r2;
        bs.s_valid = 1'b0;
        bs.s_data = '0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, cfg_done}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_shift", {31'd0, shift_en}, 0);
        check("rst_head", {31'd0, head}, 0);
        check("rst_cnt", 32'(bit_cnt), 0);
        check("rst_ready", {31'd0, bs.s_ready}, 0);
        rst = 1'b1;
        tick();
        do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
        check("t1_chain", 32'(chain), 32'hF3CA5);
        check("t1_span", last_sh - t_first, 20);
`ifndef CCFF_LOADER_CRC_EN
        check("t1_done_lat", cyc - last_sh, 0);
`endif
        check("t1_done", {31'd0, cfg_done}, 1);
        check("t1_cnt", 32'(bit_cnt), 20);
        check("t1_busy", {31'd0, busy}, 0);
        check("t1_err", {31'd0, err}, 0);
        check("t1_ready", {31'd0, bs.s_ready}, 0);
        pulse_start();
        push(8'h12);
        push(8'h34);
        bs.s_valid = 1'b0;
        n = 0;
        while (bit_cnt != 11 && n < 50) begin
            tick();
            n++;
        end
        check("t3_at11", 32'(bit_cnt), 11);
        rst = 1'b0;
        tick();
        s0 = nsh;
        check("t3_busy", {31'd0, busy}, 0);
        check("t3_shift", {31'd0, shift_en}, 0);
        check("t3_head", {31'd0, head}, 0);
        check("t3_cnt", 32'(bit_cnt), 0);
        check("t3_done", {31'd0, cfg_done}, 0);
        check("t3_ready", {31'd0, bs.s_ready}, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("t3_noshift", nsh - s0, 0);
        do_load(8'h12, 8'h34, 8'h56, 0, 1'b0);
        check("t3_chain", 32'(chain), 32'h63412);
        check("t3_reload_cnt", 32'(bit_cnt), 20);
        do_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0);
        check("t2_chain", 32'(chain), 32'hF3CA5);
        check("t2_done", {31'd0, cfg_done}, 1);
        pulse_start();
        push(8'hA5);
        bs.s_valid = 1'b0;
        pulse_start();
        check("t4_busy", {31'd0, busy}, 1);
        check("t4_cnt", 32'(bit_cnt), 1);
        push(8'h3C);
        push(8'h0F);
        push_trailer(crc_of(20'hF3CA5));
        bs.s_valid = 1'b0;
        wait_end();
        check("t4_chain", 32'(chain), 32'hF3CA5);
        check("t4_done", {31'd0, cfg_done}, 1);
        pulse_start();
        check("t4_restart_done", {31'd0, cfg_done}, 0);
        check("t4_restart_cnt", 32'(bit_cnt), 0);
        check("t4_restart_busy", {31'd0, busy}, 1);
        do_load(8'h5A, 8'hC3, 8'hF0, 0, 1'b0);
        check("t4_chain2", 32'(chain), 32'h0C35A);
`ifdef CCFF_LOADER_CRC_EN
        do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
        check("t5_good_done", {31'd0, cfg_done}, 1);
        check("t5_good_err", {31'd0, err}, 0);
        do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b1);
        check("t5_bad_err", {31'd0, err}, 1);
        check("t5_bad_done", {31'd0, cfg_done}, 0);
        check("t5_bad_busy", {31'd0, busy}, 0);
`endif
        for (int i = 0; i < 200; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            do_load(r0, r1, r2, int'($urandom_range(0, 3)), 1'b0);
            check("t6_chain", 32'(chain), {12'd0, r2[3:0], r1, r0});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
